addsub_monitor: RTL and testbench
=================================

ADDSUB_MONITOR -- requirements
Module: addsub_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 100, meaning the number of clock cycles the DUT output is observed per test vector (range 2-255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse: operands a/b/sub now applied to DUT.
REQ-005 SHALL have ports a, b  input  32 each  operands applied to DUT.
REQ-006 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-007 SHALL have port dut_ans  input  32  DUT result.
REQ-008 SHALL have port dut_cout  input  1  DUT carry-out.
REQ-009 SHALL have port dut_v  input  1  DUT signed overflow.
REQ-010 SHALL have port busy  output  1  high while a vector is under observation.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a vector's check completes.
REQ-012 SHALL have port pass  output  1  result of last check, valid from done onward.
REQ-013 SHALL have port exp_ans  output  32  golden result of last accepted vector.
REQ-014 SHALL have port settle_cycles  output  8  settle measurement of last vector.
REQ-015 SHALL have port max_settle  output  8  largest settle_cycles since reset.
REQ-016 SHALL have ports test_count, err_count  output  16 each  vectors checked / vectors failed since reset.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> CHECK -> IDLE; busy = 1 in WAIT and CHECK.
REQ-018 In IDLE, start = 1 SHALL latch a, b, sub, clear cycle counter and last-change index to 0, sample DUT outputs as reference, and enter WAIT next cycle.
REQ-019 Golden model SHALL be computed from latched operands: bb = b XOR {32{sub}}; s[32:0] = a + bb + sub; exp_ans = s[31:0]; exp_cout = s[32]; exp_v = (a[31] == bb[31]) AND (s[31] != a[31]).
REQ-020 In WAIT, each cycle the monitor SHALL compare {dut_ans, dut_cout, dut_v} against the previous sample; on any difference last-change index SHALL be set to the current cycle counter value (first WAIT cycle = 1), and the sample updated.
REQ-021 WAIT SHALL last exactly WINDOW cycles, then enter CHECK.
REQ-022 In CHECK (one cycle): pass = (dut_ans == exp_ans) AND (dut_cout == exp_cout) AND (dut_v == exp_v) using the current DUT values; settle_cycles = last-change index + 1; done = 1.
REQ-023 In CHECK, test_count SHALL increment; err_count SHALL increment when pass = 0; both SHALL saturate at 16'hFFFF.
REQ-024 In CHECK, max_settle SHALL update to settle_cycles if larger.
REQ-025 No DUT output change during WAIT SHALL yield settle_cycles = 1.
REQ-026 start while busy SHALL be ignored; latched operands SHALL not change.
REQ-027 start in the CHECK cycle SHALL be ignored; start on the cycle after done SHALL be accepted.
REQ-028 Latency: start accepted at cycle T -> done at cycle T + WINDOW + 1.
REQ-029 Result outputs (pass, exp_ans, settle_cycles) SHALL hold until the next CHECK.

Reset
REQ-030 rst = 1 SHALL force IDLE and clear busy, done, pass, exp_ans, settle_cycles, max_settle, test_count, err_count to 0, overriding start in the same cycle.
REQ-031 rst asserted mid-WAIT or in CHECK SHALL abort the vector with no done pulse and no counter update.

Verification
REQ-032 a=5, b=3, sub=0; DUT drives 8 (cout 0, v 0) changing at WAIT cycle 2 only -> done at T+WINDOW+1, pass=1, exp_ans=8, settle_cycles=3, test_count=1.
REQ-033 a=32'h7FFFFFFF, b=1, sub=0; DUT correct -> exp_ans=32'h80000000, exp_cout=0, exp_v=1, pass=1.
REQ-034 a=0, b=1, sub=1; DUT drives 32'h00000001 -> exp_ans=32'hFFFFFFFF, exp_cout=0, exp_v=0, pass=0, err_count=1.
REQ-035 DUT outputs static during WAIT -> settle_cycles=1; then vector with change at cycle 40 -> settle_cycles=41, max_settle=41; then change at cycle 10 -> max_settle stays 41.
REQ-036 start re-pulsed at WAIT cycle 5 with different operands -> ignored, exactly one done, exp_ans from first operands.
REQ-037 rst at WAIT cycle 20 -> no done, all outputs 0 next cycle; new start afterwards accepted normally.

Source files
------------

// File: rtl/addsub_monitor.sv
// Self-timed checker for a 32-bit adder/subtractor: latches operands, watches the DUT
// outputs for WINDOW cycles to measure settling, then compares against a golden model.
module addsub_monitor #(
    parameter int WINDOW = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic [31:0] dut_ans,
    input  logic        dut_cout,
    input  logic        dut_v,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] exp_ans,
    output logic [7:0]  settle_cycles,
    output logic [7:0]  max_settle,
    output logic [15:0] test_count,
    output logic [15:0] err_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [7:0] WIN = 8'(WINDOW);

    logic [1:0]  state;
    logic [1:0]  state_next;

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sub_q;
    logic [31:0] ref_ans;
    logic        ref_cout;
    logic        ref_v;

    logic [7:0]  cycle_cnt;
    logic [7:0]  last_idx;

    logic        pass_q;
    logic [31:0] exp_q;
    logic [7:0]  settle_q;
    logic [7:0]  max_q;
    logic [15:0] test_q;
    logic [15:0] err_q;

    logic        accept;
    logic        in_wait;
    logic        in_check;
    logic [7:0]  wait_idx;
    logic        window_end;
    logic        changed;

    logic [31:0] bb;
    logic [32:0] sum;
    logic [31:0] gold_ans;
    logic        gold_cout;
    logic        gold_v;
    logic        pass_now;
    logic [7:0]  settle_now;

    assign accept     = (state == IDLE) && start;
    assign in_wait    = (state == WAIT);
    assign in_check   = (state == CHECK);
    assign wait_idx   = cycle_cnt + 8'd1;
    assign window_end = (wait_idx == WIN);
    assign changed    = {dut_ans, dut_cout, dut_v} != {ref_ans, ref_cout, ref_v};

    // Golden model from the latched operands; subtraction is a + ~b + 1.
    assign bb        = b_q ^ {32{sub_q}};
    assign sum       = {1'b0, a_q} + {1'b0, bb} + 33'(sub_q);
    assign gold_ans  = sum[31:0];
    assign gold_cout = sum[32];
    assign gold_v    = (a_q[31] == bb[31]) && (sum[31] != a_q[31]);

    assign pass_now   = (dut_ans == gold_ans) && (dut_cout == gold_cout) && (dut_v == gold_v);
    assign settle_now = (last_idx == 8'hFF) ? 8'hFF : last_idx + 8'd1;

    // NOTE: every path through a combinational block assigns its outputs first,
    // otherwise synthesis infers a latch to hold the unassigned value.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = WAIT;
            WAIT:    if (window_end) state_next = CHECK;
            CHECK:                   state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cycle_cnt <= 8'd0;
            last_idx  <= 8'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                cycle_cnt <= 8'd0;
                last_idx  <= 8'd0;
            end else if (in_wait) begin
                cycle_cnt <= wait_idx;
                if (changed) last_idx <= wait_idx;
            end
        end
    end

    // NOTE: operand and reference-sample registers carry no reset; they are always
    // loaded on acceptance before anything reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q      <= a;
            b_q      <= b;
            sub_q    <= sub;
            ref_ans  <= dut_ans;
            ref_cout <= dut_cout;
            ref_v    <= dut_v;
        end else if (in_wait && changed) begin
            ref_ans  <= dut_ans;
            ref_cout <= dut_cout;
            ref_v    <= dut_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q   <= 1'b0;
            exp_q    <= 32'd0;
            settle_q <= 8'd0;
            max_q    <= 8'd0;
            test_q   <= 16'd0;
            err_q    <= 16'd0;
        end else if (in_check) begin
            pass_q   <= pass_now;
            exp_q    <= gold_ans;
            settle_q <= settle_now;
            if (settle_now > max_q)           max_q  <= settle_now;
            if (test_q != 16'hFFFF)           test_q <= test_q + 16'd1;
            if (!pass_now && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
    end

    // Results are live during the CHECK cycle and held in registers afterwards;
    // a reset landing on CHECK suppresses the done pulse.
    assign busy          = (state != IDLE);
    assign done          = in_check && !rst;
    assign pass          = done ? pass_now   : pass_q;
    assign exp_ans       = done ? gold_ans   : exp_q;
    assign settle_cycles = done ? settle_now : settle_q;
    assign max_settle    = max_q;
    assign test_count    = test_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_addsub_monitor.sv
// Directed bench for addsub_monitor: hand-computed vectors, settle timing, ignored
// starts, back-to-back acceptance and reset aborts.
module tb_addsub_monitor;

    localparam int WINDOW = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] dut_ans;
    logic        dut_cout;
    logic        dut_v;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] exp_ans;
    logic [7:0]  settle_cycles;
    logic [7:0]  max_settle;
    logic [15:0] test_count;
    logic [15:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_tc = 0;
    int exp_ec = 0;
    int exp_max = 0;

    always #5 clk = ~clk;

    addsub_monitor #(.WINDOW(WINDOW)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .a             (a),
        .b             (b),
        .sub           (sub),
        .dut_ans       (dut_ans),
        .dut_cout      (dut_cout),
        .dut_v         (dut_v),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .exp_ans       (exp_ans),
        .settle_cycles (settle_cycles),
        .max_settle    (max_settle),
        .test_count    (test_count),
        .err_count     (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full vector: init values at start, optional change to final values at WAIT
    // cycle chg, optional stray start at WAIT cycle repulse, optional start in CHECK.
    task automatic run_vector(input string name,
                              input logic [31:0] va, input logic [31:0] vb, input logic vs,
                              input logic [31:0] ia, input logic ic, input logic iv,
                              input logic [31:0] fa, input logic fc, input logic fv,
                              input int chg, input int repulse, input bit poke_check,
                              input logic exp_pass, input logic [31:0] exp_a,
                              input logic [7:0] exp_settle);
        int early;
        early = 0;
        dut_ans = ia; dut_cout = ic; dut_v = iv;
        a = va; b = vb; sub = vs; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va; b = ~vb; sub = ~vs;
        for (int k = 1; k <= WINDOW; k++) begin
            if (k == chg) begin
                dut_ans = fa; dut_cout = fc; dut_v = fv;
            end
            if (k == repulse) begin
                start = 1'b1; a = 32'h1; b = 32'h1; sub = 1'b0;
            end
            if (done !== 1'b0 || busy !== 1'b1) early++;
            tick();
            start = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL %s.wait_phase: %0d bad cycles, want 0", name, early); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s.done_at_check: got %b want 1", name, done); end
        n_cmp++; if (pass !== exp_pass) begin n_bad++; $display("FAIL %s.pass: got %b want %b", name, pass, exp_pass); end
        n_cmp++; if (exp_ans !== exp_a) begin n_bad++; $display("FAIL %s.exp_ans: got %h want %h", name, exp_ans, exp_a); end
        n_cmp++; if (settle_cycles !== exp_settle) begin n_bad++; $display("FAIL %s.settle: got %0d want %0d", name, settle_cycles, exp_settle); end
        exp_tc++;
        if (!exp_pass) exp_ec++;
        if (int'(exp_settle) > exp_max) exp_max = int'(exp_settle);
        if (poke_check) begin
            start = 1'b1; a = 32'd100; b = 32'd100; sub = 1'b0;
        end
        tick();
        start = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s.done_drop: got %b want 0", name, done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s.busy_after: got %b want 0", name, busy); end
        n_cmp++; if (pass !== exp_pass) begin n_bad++; $display("FAIL %s.pass_hold: got %b want %b", name, pass, exp_pass); end
        n_cmp++; if (exp_ans !== exp_a) begin n_bad++; $display("FAIL %s.exp_ans_hold: got %h want %h", name, exp_ans, exp_a); end
        n_cmp++; if (settle_cycles !== exp_settle) begin n_bad++; $display("FAIL %s.settle_hold: got %0d want %0d", name, settle_cycles, exp_settle); end
        n_cmp++; if (test_count !== 16'(exp_tc)) begin n_bad++; $display("FAIL %s.test_count: got %0d want %0d", name, test_count, exp_tc); end
        n_cmp++; if (err_count !== 16'(exp_ec)) begin n_bad++; $display("FAIL %s.err_count: got %0d want %0d", name, err_count, exp_ec); end
        n_cmp++; if (max_settle !== 8'(exp_max)) begin n_bad++; $display("FAIL %s.max_settle: got %0d want %0d", name, max_settle, exp_max); end
    endtask

    task automatic check_cleared(input string name);
        n_cmp++;
        if ({busy, done, pass, exp_ans, settle_cycles, max_settle, test_count, err_count} !== '0) begin
            n_bad++;
            $display("FAIL %s.cleared: busy=%b done=%b pass=%b exp=%h settle=%0d max=%0d tc=%0d ec=%0d want all 0",
                     name, busy, done, pass, exp_ans, settle_cycles, max_settle, test_count, err_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd3; sub = 1'b0;
        dut_ans = 32'd0; dut_cout = 1'b0; dut_v = 1'b0;
        tick();
        tick();
        check_cleared("reset");
        rst = 1'b0; start = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset.start_overridden: busy=%b want 0", busy); end
        tick();
    endtask

    task automatic test_arith();
        // 5+3 settles at WAIT cycle 2
        run_vector("add_5_3", 32'd5, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0,
                   2, 0, 1'b0, 1'b1, 32'd8, 8'd3);
        run_vector("add_ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1,
                   1, 0, 1'b0, 1'b1, 32'h80000000, 8'd2);
        run_vector("sub_0_1_bad", 32'd0, 32'd1, 1'b1, 32'd0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0,
                   1, 0, 1'b0, 1'b0, 32'hFFFFFFFF, 8'd2);
        run_vector("sub_5_3", 32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0, 32'd2, 1'b1, 1'b0,
                   0, 0, 1'b0, 1'b1, 32'd2, 8'd1);
        run_vector("bad_cout", 32'd5, 32'd3, 1'b1, 32'd2, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0,
                   0, 0, 1'b0, 1'b0, 32'd2, 8'd1);
        run_vector("bad_v", 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0,
                   0, 0, 1'b0, 1'b0, 32'h80000000, 8'd1);
    endtask

    task automatic test_settle();
        run_vector("static", 32'd7, 32'd8, 1'b0, 32'd15, 1'b0, 1'b0, 32'd15, 1'b0, 1'b0,
                   0, 0, 1'b0, 1'b1, 32'd15, 8'd1);
        run_vector("chg40", 32'd7, 32'd8, 1'b0, 32'd0, 1'b0, 1'b0, 32'd15, 1'b0, 1'b0,
                   40, 0, 1'b0, 1'b1, 32'd15, 8'd41);
        run_vector("chg10", 32'd7, 32'd8, 1'b0, 32'd0, 1'b0, 1'b0, 32'd15, 1'b0, 1'b0,
                   10, 0, 1'b0, 1'b1, 32'd15, 8'd11);
    endtask

    task automatic test_back_to_back();
        // stray start at WAIT cycle 5 and another in CHECK, then a start right after done
        run_vector("repulse", 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0,
                   0, 5, 1'b1, 1'b1, 32'd30, 8'd1);
        run_vector("b2b", 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0,
                   0, 0, 1'b0, 1'b1, 32'd0, 8'd1);
    endtask

    task automatic test_reset_mid_wait();
        int dones;
        dones = 0;
        dut_ans = 32'd18; dut_cout = 1'b0; dut_v = 1'b0;
        a = 32'd9; b = 32'd9; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cleared("rst_wait");
        for (int k = 0; k < WINDOW + 5; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) dones++;
            tick();
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rst_wait.no_done: %0d active cycles, want 0", dones); end
        exp_tc = 0; exp_ec = 0; exp_max = 0;
        run_vector("after_rst", 32'd5, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0,
                   2, 0, 1'b0, 1'b1, 32'd8, 8'd3);
    endtask

    task automatic test_reset_in_check();
        dut_ans = 32'd3; dut_cout = 1'b0; dut_v = 1'b0;
        a = 32'd1; b = 32'd2; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= WINDOW; k++) tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_check.done: got %b want 0", done); end
        tick();
        rst = 1'b0;
        check_cleared("rst_check");
        tick();
        n_cmp++; if (test_count !== 16'd0) begin n_bad++; $display("FAIL rst_check.test_count: got %0d want 0", test_count); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        dut_ans = '0; dut_cout = 1'b0; dut_v = 1'b0;
        test_reset();
        test_arith();
        test_settle();
        test_back_to_back();
        test_reset_mid_wait();
        test_reset_in_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
